// File: rtl/vscale_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// vscale_mem_arbiter_if
//
// Bundles every handshake and bus signal around the vscale memory arbiter:
//   imem_*  : instruction fetch port of the pipeline (address + data phase)
//   dmem_*  : load/store port of the pipeline (address + data phase)
//   bus_*   : shared two-phase memory bus towards the platform
//
// Modports:
//   slave  : the arbiter's view (consumes core requests and bus responses)
//   master : the environment's view (core + memory side, e.g. a testbench)
// ---------------------------------------------------------------------------
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef MEM_TYPE_WIDTH
`define MEM_TYPE_WIDTH 3
`endif
`ifndef MEM_TYPE_LW
`define MEM_TYPE_LW 3'd2
`endif

interface vscale_mem_arbiter_if;
    // Instruction port
    logic                       imem_en;
    logic [`XPR_LEN-1:0]        imem_addr;
    logic [`XPR_LEN-1:0]        imem_rdata;
    logic                       imem_wait;
    logic                       imem_badmem_e;

    // Data port
    logic                       dmem_en;
    logic                       dmem_wen;
    logic [`MEM_TYPE_WIDTH-1:0] dmem_size;
    logic [`XPR_LEN-1:0]        dmem_addr;
    logic [`XPR_LEN-1:0]        dmem_wdata_delayed;
    logic [`XPR_LEN-1:0]        dmem_rdata;
    logic                       dmem_wait;
    logic                       dmem_badmem_e;

    // Shared memory bus
    logic                       bus_en;
    logic                       bus_wen;
    logic [`MEM_TYPE_WIDTH-1:0] bus_size;
    logic [`XPR_LEN-1:0]        bus_addr;
    logic [`XPR_LEN-1:0]        bus_wdata;
    logic [`XPR_LEN-1:0]        bus_rdata;
    logic                       bus_wait;
    logic                       bus_badmem_e;

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata, imem_wait, imem_badmem_e,
        input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        output dmem_rdata, dmem_wait, dmem_badmem_e,
        output bus_en, bus_wen, bus_size, bus_addr, bus_wdata,
        input  bus_rdata, bus_wait, bus_badmem_e
    );

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata, imem_wait, imem_badmem_e,
        output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        input  dmem_rdata, dmem_wait, dmem_badmem_e,
        input  bus_en, bus_wen, bus_size, bus_addr, bus_wdata,
        output bus_rdata, bus_wait, bus_badmem_e
    );
endinterface

// File: rtl/vscale_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vscale_mem_arbiter
//
// Shares one pipelined single-port memory bus between the vscale instruction
// port and data port. The bus is two-phase: the address phase carries
// en/wen/size/addr, the following data phase carries wdata/rdata/badmem, and
// bus_wait stretches the data phase (holding both phases).
//
// The data port has priority in the address phase; a saturating starvation
// counter forces an instruction grant after STARVE_LIMIT consecutive data
// grants that kept a pending fetch waiting.
//
// Ports:
//   clk    : core clock
//   reset  : synchronous, active-high reset
//   mem    : vscale_mem_arbiter_if.slave (imem_*, dmem_*, bus_* signals)
//
// Parameters:
//   STARVE_LIMIT : data grants tolerated while a fetch is pending (>= 1)
//   CNT_WIDTH    : width of the starvation counter (must hold STARVE_LIMIT)
// ---------------------------------------------------------------------------
module vscale_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    vscale_mem_arbiter_if.slave  mem
);

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IMEM = 2'd1,
        OWNER_DMEM = 2'd2
    } owner_e;

    localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

    owner_e                dp_owner_q, dp_owner_d;
    logic                  dp_wen_q, dp_wen_d;
    logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;

    logic grant_i;
    logic grant_d;
    logic starve_full;

    assign starve_full = (starve_cnt_q == STARVE_MAX);

    // Address-phase arbitration. Grants are suppressed during reset so the
    // bus sees no request while the arbiter is being cleared.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            grant_i = mem.imem_en & (~mem.dmem_en | starve_full);
            grant_d = mem.dmem_en & ~grant_i;
        end
    end

    // Address-phase bus mux. A fetch is always a full-word read.
    always_comb begin
        mem.bus_en   = grant_i | grant_d;
        mem.bus_wen  = 1'b0;
        mem.bus_size = '0;
        mem.bus_addr = '0;
        if (grant_i) begin
            mem.bus_size = `MEM_TYPE_LW;
            mem.bus_addr = mem.imem_addr;
        end else if (grant_d) begin
            mem.bus_wen  = mem.dmem_wen;
            mem.bus_size = mem.dmem_size;
            mem.bus_addr = mem.dmem_addr;
        end
    end

    // Next-state values for the data-phase owner and the starvation counter.
    // The counter only grows while a fetch is actually being held off by a
    // data grant; anything else (fetch granted or no fetch pending) clears it.
    always_comb begin
        dp_owner_d = OWNER_NONE;
        if (grant_i) begin
            dp_owner_d = OWNER_IMEM;
        end else if (grant_d) begin
            dp_owner_d = OWNER_DMEM;
        end
        dp_wen_d = grant_d & mem.dmem_wen;
        starve_cnt_d = '0;
        if (grant_d & mem.imem_en) begin
            starve_cnt_d = starve_full ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // Phase advance: a stalled bus freezes the whole arbiter so both phases
    // stay aligned with the requesters, who hold their inputs while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_owner_q   <= OWNER_NONE;
            dp_wen_q     <= 1'b0;
            starve_cnt_q <= '0;
        end else if (!mem.bus_wait) begin
            dp_owner_q   <= dp_owner_d;
            dp_wen_q     <= dp_wen_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Per-port stalls: lost arbitration, own data phase stretched, or a new
    // request that cannot be accepted because the bus is stalled.
    assign mem.imem_wait = ~reset & ((mem.imem_en & ~grant_i) |
                                     ((dp_owner_q == OWNER_IMEM) & mem.bus_wait) |
                                     (mem.imem_en & mem.bus_wait));
    assign mem.dmem_wait = ~reset & ((mem.dmem_en & ~grant_d) |
                                     ((dp_owner_q == OWNER_DMEM) & mem.bus_wait) |
                                     (mem.dmem_en & mem.bus_wait));

    // Data-phase routing. Read data is broadcast; each port only consumes it
    // when it owns the phase. Errors are steered to the owner only, and a
    // phase cut short by reset never reports an error.
    assign mem.imem_rdata    = mem.bus_rdata;
    assign mem.dmem_rdata    = mem.bus_rdata;
    assign mem.imem_badmem_e = ~reset & mem.bus_badmem_e & (dp_owner_q == OWNER_IMEM);
    assign mem.dmem_badmem_e = ~reset & mem.bus_badmem_e & (dp_owner_q == OWNER_DMEM);
    assign mem.bus_wdata     = ((dp_owner_q == OWNER_DMEM) && dp_wen_q) ?
                               mem.dmem_wdata_delayed : '0;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vscale_mem_arbiter
//
// Self-checking bench for vscale_mem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// arbitration rules kept in plain integers.
// ---------------------------------------------------------------------------
module tb_vscale_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam logic [2:0] SIZE_LW = 3'd2;
    localparam logic [2:0] SIZE_SW = 3'd2;

    logic clk;
    logic reset;

    vscale_mem_arbiter_if arbIf ();

    vscale_mem_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_WIDTH    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mem   (arbIf)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int totalChecks = 0;
    int badChecks   = 0;

    // Behavioural model: who owns the data phase (0 none, 1 fetch, 2 data),
    // whether that phase is a store, and how many data grants in a row have
    // kept a fetch waiting.
    int modelOwner = 0;
    int modelWen   = 0;
    int modelCnt   = 0;

    // Values observed during the most recent cycle, for directed checks
    logic        obsBusEn, obsBusWen, obsImemWait, obsDmemWait;
    logic        obsImemBad, obsDmemBad;
    logic [2:0]  obsBusSize;
    logic [31:0] obsBusAddr, obsBusWdata, obsDmemRdata, obsImemRdata;

    // Single comparison point: counts the check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%h expected=%h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs after the falling edge, checks the
    // combinational outputs against the model mid-cycle, then advances the
    // model at the rising edge.
    task automatic applyStimulus(input logic rst, input logic ien, input logic [31:0] iaddr,
                                 input logic den, input logic dwen, input logic [2:0] dsize,
                                 input logic [31:0] daddr, input logic [31:0] dwdata,
                                 input logic [31:0] brdata, input logic bw, input logic bbad);
        bit gi, gd;
        bit expIWait, expDWait;
        logic [31:0] expAddr, expWdata;
        @(negedge clk);
        reset                    = rst;
        arbIf.imem_en            = ien;
        arbIf.imem_addr          = iaddr;
        arbIf.dmem_en            = den;
        arbIf.dmem_wen           = dwen;
        arbIf.dmem_size          = dsize;
        arbIf.dmem_addr          = daddr;
        arbIf.dmem_wdata_delayed = dwdata;
        arbIf.bus_rdata          = brdata;
        arbIf.bus_wait           = bw;
        arbIf.bus_badmem_e       = bbad;
        #1;
        obsBusEn     = arbIf.bus_en;
        obsBusWen    = arbIf.bus_wen;
        obsBusSize   = arbIf.bus_size;
        obsBusAddr   = arbIf.bus_addr;
        obsBusWdata  = arbIf.bus_wdata;
        obsImemWait  = arbIf.imem_wait;
        obsDmemWait  = arbIf.dmem_wait;
        obsImemBad   = arbIf.imem_badmem_e;
        obsDmemBad   = arbIf.dmem_badmem_e;
        obsDmemRdata = arbIf.dmem_rdata;
        obsImemRdata = arbIf.imem_rdata;

        gi = ien && (!den || modelCnt == STARVE_LIMIT);
        gd = den && !gi;

        checkOutput("imem_rdata", obsImemRdata, brdata);
        checkOutput("dmem_rdata", obsDmemRdata, brdata);
        if (rst) begin
            checkOutput("rst_bus_en", {31'd0, obsBusEn}, 32'd0);
            checkOutput("rst_imem_wait", {31'd0, obsImemWait}, 32'd0);
            checkOutput("rst_dmem_wait", {31'd0, obsDmemWait}, 32'd0);
            checkOutput("rst_imem_bad", {31'd0, obsImemBad}, 32'd0);
            checkOutput("rst_dmem_bad", {31'd0, obsDmemBad}, 32'd0);
        end else begin
            expAddr  = gi ? iaddr : (gd ? daddr : 32'd0);
            expWdata = (modelOwner == 2 && modelWen == 1) ? dwdata : 32'd0;
            expIWait = (ien && !gi) || (modelOwner == 1 && bw) || (ien && bw);
            expDWait = (den && !gd) || (modelOwner == 2 && bw) || (den && bw);
            checkOutput("bus_en", {31'd0, obsBusEn}, {31'd0, gi || gd});
            checkOutput("bus_addr", obsBusAddr, expAddr);
            checkOutput("bus_wen", {31'd0, obsBusWen}, {31'd0, gd && dwen});
            if (gi || gd)
                checkOutput("bus_size", {29'd0, obsBusSize}, {29'd0, gi ? SIZE_LW : dsize});
            checkOutput("bus_wdata", obsBusWdata, expWdata);
            checkOutput("imem_wait", {31'd0, obsImemWait}, {31'd0, expIWait});
            checkOutput("dmem_wait", {31'd0, obsDmemWait}, {31'd0, expDWait});
            checkOutput("imem_bad", {31'd0, obsImemBad}, {31'd0, bbad && modelOwner == 1});
            checkOutput("dmem_bad", {31'd0, obsDmemBad}, {31'd0, bbad && modelOwner == 2});
        end

        @(posedge clk);
        if (rst) begin
            modelOwner = 0;
            modelWen   = 0;
            modelCnt   = 0;
        end else if (!bw) begin
            modelOwner = gi ? 1 : (gd ? 2 : 0);
            modelWen   = (gd && dwen) ? 1 : 0;
            if (gd && ien)
                modelCnt = (modelCnt + 1 > STARVE_LIMIT) ? STARVE_LIMIT : modelCnt + 1;
            else
                modelCnt = 0;
        end
    endtask

    initial begin
        reset = 1'b1;
        arbIf.imem_en = 1'b0;
        arbIf.imem_addr = '0;
        arbIf.dmem_en = 1'b0;
        arbIf.dmem_wen = 1'b0;
        arbIf.dmem_size = '0;
        arbIf.dmem_addr = '0;
        arbIf.dmem_wdata_delayed = '0;
        arbIf.bus_rdata = '0;
        arbIf.bus_wait = 1'b0;
        arbIf.bus_badmem_e = 1'b0;

        // Reset state
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h1, 0, 0);

        // Fetch-only stream at 0x100, no bubbles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 0, 32'h1000 + i, 0, 0);
            checkOutput("t1_bus_en", {31'd0, obsBusEn}, 32'd1);
            checkOutput("t1_bus_addr", obsBusAddr, 32'h100);
            checkOutput("t1_imem_wait", {31'd0, obsImemWait}, 32'd0);
            checkOutput("t1_dmem_wait", {31'd0, obsDmemWait}, 32'd0);
        end

        // Store beats a fetch, then its data phase carries the store data
        applyStimulus(0, 1, 32'h104, 1, 1, SIZE_SW, 32'h2004, 0, 0, 0, 0);
        checkOutput("t2_bus_addr", obsBusAddr, 32'h2004);
        checkOutput("t2_bus_wen", {31'd0, obsBusWen}, 32'd1);
        checkOutput("t2_bus_size", {29'd0, obsBusSize}, {29'd0, SIZE_SW});
        checkOutput("t2_imem_wait", {31'd0, obsImemWait}, 32'd1);
        applyStimulus(0, 1, 32'h104, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        checkOutput("t2_bus_wdata", obsBusWdata, 32'hDEADBEEF);
        checkOutput("t2_fetch_addr", obsBusAddr, 32'h104);
        checkOutput("t2_fetch_wait", {31'd0, obsImemWait}, 32'd0);

        // Starvation: four data grants, then the fetch is forced through
        for (int i = 0; i < STARVE_LIMIT + 1; i++) begin
            applyStimulus(0, 1, 32'h108, 1, 0, 3'd2, 32'h3000 + 4 * i, 0, 0, 0, 0);
            checkOutput("t3_dmem_wait", {31'd0, obsDmemWait}, (i == STARVE_LIMIT) ? 32'd1 : 32'd0);
            checkOutput("t3_bus_addr", obsBusAddr, (i == STARVE_LIMIT) ? 32'h108 : 32'h3000 + 4 * i);
        end
        applyStimulus(0, 1, 32'h10C, 1, 0, 3'd2, 32'h3100, 0, 0, 0, 0);
        checkOutput("t3_cnt_cleared", {31'd0, obsDmemWait}, 32'd0);

        // Load stretched by two bus_wait cycles
        applyStimulus(0, 1, 32'h10C, 1, 0, 3'd2, 32'h3200, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 32'h10C, 0, 0, 0, 0, 0, 32'hBAD0, 1, 0);
            checkOutput("t4_dmem_wait", {31'd0, obsDmemWait}, 32'd1);
            checkOutput("t4_imem_wait", {31'd0, obsImemWait}, 32'd1);
        end
        applyStimulus(0, 1, 32'h10C, 0, 0, 0, 0, 0, 32'hCAFE, 0, 0);
        checkOutput("t4_load_data", obsDmemRdata, 32'hCAFE);
        checkOutput("t4_dmem_done", {31'd0, obsDmemWait}, 32'd0);

        // Fetch data phase reports a bus error
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("t5_imem_bad", {31'd0, obsImemBad}, 32'd1);
        checkOutput("t5_dmem_bad", {31'd0, obsDmemBad}, 32'd0);

        // Reset during a stalled data-port phase
        applyStimulus(0, 0, 0, 1, 0, 3'd2, 32'h4000, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 32'h200, 1, 1, 3'd2, 32'h4004, 0, 0, 1, 1);
            checkOutput("t6_bus_en", {31'd0, obsBusEn}, 32'd0);
            checkOutput("t6_dmem_wait", {31'd0, obsDmemWait}, 32'd0);
            checkOutput("t6_imem_wait", {31'd0, obsImemWait}, 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("t6_dmem_bad", {31'd0, obsDmemBad}, 32'd0);
        checkOutput("t6_imem_bad", {31'd0, obsImemBad}, 32'd0);

        // Randomized traffic with occasional stalls, errors and resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(39) == 0),
                          ($urandom_range(3) != 0),
                          $urandom & 32'hFFFC,
                          ($urandom_range(2) != 0),
                          $urandom_range(1),
                          3'($urandom_range(2)),
                          $urandom,
                          $urandom,
                          $urandom,
                          ($urandom_range(3) == 0),
                          ($urandom_range(7) == 0));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
